alu_exec_unit: RTL and testbench

Execution-stage ALU for the RISC-V core. It is the consumer of the 4-bit ALUControl code produced by the ALU control decoder. Single-cycle logic operations complete in one cycle. Shifts run iteratively, one bit per cycle, and an optional multiply uses shift-add. Operands and results move through valid/ready handshakes, so the datapath can stall on multi-cycle operations.

---
 rtl/alu_exec_unit.sv | 167 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU: single-cycle logic/arith ops, bit-serial shifts, optional shift-add multiply.
// Define ALU_EXEC_MUL_EN to build the multiplier for code 1000; otherwise that code is illegal.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_NOR = 4'b1100;

`ifdef ALU_EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [3:0]       op_code;
    logic [5:0]       count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] load_result;
    logic [WIDTH-1:0] busy_result;
    logic             is_shift;
    logic             is_mul;
    logic             legal;
    logic             start_busy;

    assign in_ready = (state == IDLE) && !rst;

    assign is_shift   = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
    assign is_mul     = MUL_EN && (alu_ctrl == OP_MUL);
    assign legal      = is_shift || is_mul ||
                        (alu_ctrl == OP_AND) || (alu_ctrl == OP_OR)  || (alu_ctrl == OP_ADD) ||
                        (alu_ctrl == OP_SUB) || (alu_ctrl == OP_SLT) || (alu_ctrl == OP_NOR);
    assign start_busy = (is_shift && (op_b[4:0] != 5'd0)) || is_mul;

    // Result registered at accept; a zero-distance shift passes A straight through.
    always_comb begin
        load_result = '0;
        case (alu_ctrl)
            OP_AND:                 load_result = op_a & op_b;
            OP_OR:                  load_result = op_a | op_b;
            OP_ADD:                 load_result = op_a + op_b;
            OP_SUB:                 load_result = op_a - op_b;
            OP_SLT:                 load_result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_NOR:                 load_result = ~(op_a | op_b);
            OP_SLL, OP_SRL, OP_SRA: load_result = op_a;
            default:                load_result = '0;
        endcase
    end

    always_comb begin
        acc_next = acc;
        case (op_code)
            OP_SLL:  acc_next = {acc[WIDTH-2:0], 1'b0};
            OP_SRL:  acc_next = {1'b0, acc[WIDTH-1:1]};
            OP_SRA:  acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
            default: acc_next = acc;
        endcase
    end

`ifdef ALU_EXEC_MUL_EN
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] product;
    logic [WIDTH-1:0] product_next;

    assign product_next = mplier[0] ? (product + mcand) : product;
    assign busy_result  = (op_code == OP_MUL) ? product_next : acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else if (state == IDLE && in_valid && is_mul) begin
            mcand   <= op_a;
            mplier  <= op_b;
            product <= '0;
        end else if (state == BUSY) begin
            mcand   <= {mcand[WIDTH-2:0], 1'b0};
            mplier  <= {1'b0, mplier[WIDTH-1:1]};
            product <= product_next;
        end
    end
`else
    assign busy_result = acc_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_code     <= '0;
            count       <= '0;
            acc         <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_code <= alu_ctrl;
                        acc     <= op_a;
                        count   <= is_mul ? 6'd32 : {1'b0, op_b[4:0]};
                        if (legal && start_busy) begin
                            state <= BUSY;
                        end else begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            out_result  <= legal ? load_result : '0;
                            out_zero    <= legal ? (load_result == '0) : 1'b1;
                            out_illegal <= !legal;
                        end
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    count <= count - 6'd1;
                    if (count == 6'd1) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        out_result  <= busy_result;
                        out_zero    <= (busy_result == '0);
                        out_illegal <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: operator-level model plus directed vectors.
// Follows ALU_EXEC_MUL_EN the same way the design does.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_ctrl = 4'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_ctrl   (alu_ctrl),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_illegal(out_illegal)
    );

    bit          pending = 1'b0;
    bit          seen = 1'b0;
    bit          rst_q = 1'b1;
    logic [31:0] exp_res;
    bit          exp_ill;
    int          exp_lat;
    int          acc_cyc = 0;
    int          cyc = 0;
    logic [31:0] last_res = '0;
    bit          last_zero;
    bit          last_ill;
    int          last_lat;
    int          valid_count = 0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s got=timeout want=completion (t=%0t)", name, $time);
    endtask

    // What the unit must produce, from the operator definitions alone.
    function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit ill, output int lat);
        ill = 1'b0;
        lat = 1;
        r   = '0;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: r = ~(a | b);
            4'b0011: begin r = a << b[4:0];                   lat = 1 + int'(b[4:0]); end
            4'b0100: begin r = a >> b[4:0];                   lat = 1 + int'(b[4:0]); end
            4'b0101: begin r = 32'($signed(a) >>> b[4:0]);   lat = 1 + int'(b[4:0]); end
`ifdef ALU_EXEC_MUL_EN
            4'b1000: begin r = a * b; lat = 33; end
`endif
            default: begin r = '0; ill = 1'b1; end
        endcase
    endfunction

    // Track accepts and retirements using pre-edge values.
    always @(posedge clk) begin
        cyc++;
        rst_q = rst;
        if (rst) begin
            pending = 1'b0;
        end else begin
            if (pending && out_valid && out_ready) pending = 1'b0;
            if (in_valid && in_ready) begin
                model(alu_ctrl, op_a, op_b, exp_res, exp_ill, exp_lat);
                pending = 1'b1;
                seen    = 1'b0;
                acc_cyc = cyc;
            end
        end
    end

    always @(negedge clk) begin
        int elapsed;
        if (out_valid === 1'b1) valid_count++;
        checkOutput("in_ready", in_ready, !rst && !pending);
        if (rst_q) begin
            checkOutput("rst_outputs", {out_valid, out_zero, out_illegal, out_result}, 35'd0);
        end else if (pending) begin
            elapsed = cyc - acc_cyc + 1;
            checkOutput("out_valid", out_valid, elapsed >= exp_lat);
            if (out_valid === 1'b1) begin
                checkOutput("result", out_result, exp_res);
                checkOutput("zero", out_zero, exp_res == 32'd0);
                checkOutput("illegal", out_illegal, exp_ill);
                if (!seen) begin
                    seen = 1'b1;
                    checkOutput("latency", elapsed, exp_lat);
                    last_res  = out_result;
                    last_zero = out_zero;
                    last_ill  = out_illegal;
                    last_lat  = elapsed;
                end
            end
        end else begin
            checkOutput("idle_valid", out_valid, 1'b0);
        end
    end

    // Called at posedge+2; returns at posedge+2 after the accept edge.
    task automatic applyStimulus(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        bit took = 1'b0;
        in_valid = 1'b1;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        for (int i = 0; i < 50 && !took; i++) begin
            @(posedge clk);
            if (in_ready && !rst) took = 1'b1;
        end
        #2;
        in_valid = 1'b0;
        if (!took) failNow("accept_timeout");
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (pending && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (pending) failNow("done_timeout");
    endtask

    task automatic runOp(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        applyStimulus(c, a, b);
        waitDone(60);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got=hang want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int vc0;
        int n;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", in_ready, 1'b0);
        checkOutput("rst_result", out_result, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", in_ready, 1'b1);
        @(posedge clk);
        #2;

        runOp(4'b0010, 32'h7FFF_FFFF, 32'd1);
        checkOutput("add_res", last_res, 32'h8000_0000);
        checkOutput("add_zero", last_zero, 1'b0);
        checkOutput("add_lat", last_lat, 1);

        runOp(4'b0110, 32'd5, 32'd5);
        checkOutput("sub_res", last_res, 32'd0);
        checkOutput("sub_zero", last_zero, 1'b1);
        runOp(4'b0111, 32'hFFFF_FFFF, 32'd1);
        checkOutput("slt_neg", last_res, 32'd1);
        runOp(4'b0111, 32'd1, 32'hFFFF_FFFF);
        checkOutput("slt_pos", last_res, 32'd0);
        runOp(4'b1100, 32'h0F0F_0000, 32'h0000_00FF);
        checkOutput("nor_res", last_res, 32'hF0F0_FF00);
        runOp(4'b0001, 32'h1200_0034, 32'h0056_7800);

        runOp(4'b0101, 32'h8000_0000, 32'd4);
        checkOutput("sra_res", last_res, 32'hF800_0000);
        checkOutput("sra_lat", last_lat, 5);
        runOp(4'b0100, 32'h8000_0000, 32'd4);
        checkOutput("srl_res", last_res, 32'h0800_0000);
        runOp(4'b0011, 32'd1, 32'd0);
        checkOutput("sll0_res", last_res, 32'd1);
        checkOutput("sll0_lat", last_lat, 1);
        runOp(4'b0011, 32'h0000_00A5, 32'hFFFF_FFE3);

        // Backpressure: result parked in DONE for ten cycles.
        out_ready = 1'b0;
        applyStimulus(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        repeat (10) @(negedge clk);
        checkOutput("bp_hold", out_result, 32'hF000_F000);
        checkOutput("bp_ready", in_ready, 1'b0);
        @(posedge clk);
        #2 out_ready = 1'b1;
        @(posedge clk);
        #2 out_ready = 1'b0;
        @(negedge clk);
        checkOutput("bp_ready_after", in_ready, 1'b1);
        out_ready = 1'b1;
        @(posedge clk);
        #2;

        // Reset in the middle of a long shift.
        vc0 = valid_count;
        applyStimulus(4'b0011, 32'd1, 32'd31);
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midrst_valid", out_valid, 1'b0);
        checkOutput("midrst_result", out_result, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        checkOutput("midrst_no_valid", valid_count - vc0, 0);

        runOp(4'b1000, 32'h0001_0001, 32'h0001_0001);
`ifdef ALU_EXEC_MUL_EN
        checkOutput("mul_res", last_res, 32'h0002_0001);
        checkOutput("mul_lat", last_lat, 33);
`else
        checkOutput("mul_ill_res", last_res, 32'd0);
        checkOutput("mul_ill_flag", last_ill, 1'b1);
        checkOutput("mul_ill_lat", last_lat, 1);
`endif
        runOp(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
        checkOutput("ill_res", last_res, 32'd0);
        checkOutput("ill_flag", last_ill, 1'b1);
        runOp(4'b0010, 32'd2, 32'd3);
        checkOutput("post_ill_flag", last_ill, 1'b0);
        checkOutput("post_ill_res", last_res, 32'd5);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
